// File: rtl/trace_pkg.sv
// trace_pkg: shared types and constants for the retirement trace unit.
// Optional feature macro: TRACE_CYCLE_STAMP_EN adds a 16-bit cycle stamp to every record.
package trace_pkg;

    localparam int TRACE_AW = 32;
    localparam int TRACE_DW = 32;
    localparam int STAMP_W  = 16;

    // One captured retirement.
    typedef struct packed {
        logic [TRACE_AW-1:0] pc;
        logic [TRACE_DW-1:0] inst;
        logic [4:0]          rd;
        logic [TRACE_DW-1:0] wdata;
`ifdef TRACE_CYCLE_STAMP_EN
        logic [STAMP_W-1:0]  cycle;
`endif
    } trace_rec_t;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DUMP    = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_END  = 2'b01;
    localparam logic [1:0] CAUSE_WDOG = 2'b10;

endpackage

// File: rtl/trace_capture_if.sv
// trace_if: retirement input bus and dump output stream of the trace unit.
// Optional feature macro: TRACE_CYCLE_STAMP_EN adds the dump_cycle field.
interface trace_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          ret_valid;
    logic [AW-1:0] ret_pc;
    logic [DW-1:0] ret_inst;
    logic [4:0]    ret_rd;
    logic [DW-1:0] ret_wdata;

    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_pc;
    logic [DW-1:0] dump_inst;
    logic [4:0]    dump_rd;
    logic [DW-1:0] dump_wdata;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [15:0]   dump_cycle;
`endif

    // Core / host side: drives retirements, consumes the dump stream.
    modport master (
        output ret_valid, output ret_pc, output ret_inst, output ret_rd, output ret_wdata,
        output dump_ready,
`ifdef TRACE_CYCLE_STAMP_EN
        input dump_cycle,
`endif
        input dump_valid, input dump_pc, input dump_inst, input dump_rd, input dump_wdata
    );

    // Trace unit side.
    modport slave (
        input ret_valid, input ret_pc, input ret_inst, input ret_rd, input ret_wdata,
        input dump_ready,
`ifdef TRACE_CYCLE_STAMP_EN
        output dump_cycle,
`endif
        output dump_valid, output dump_pc, output dump_inst, output dump_rd, output dump_wdata
    );

endinterface

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x W simple dual-port register array, one write port and
// a registered read port whose output holds until the next read request.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_d;
    logic [W-1:0] rdata_q;

    // Storage array write port; contents need no reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read data updates only on a read request so the consumer sees stable fields.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Registered read port, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/trace_capture.sv
// trace_capture: records retired instructions into a circular buffer, halts on
// an end address or a retirement watchdog, then streams records oldest first.
// Optional feature macro: TRACE_CYCLE_STAMP_EN stamps each record with a cycle count.
module trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AW          = TRACE_AW,
    parameter int DW          = TRACE_DW,
    parameter int STALL_LIMIT = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] end_word,
    output logic          halted,
    output logic [1:0]    halt_cause,
    output logic          overflow,
    output logic          dump_done,
    trace_if.slave        bus
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(STALL_LIMIT);
    localparam int REC_W = $bits(trace_rec_t);

    trace_state_e  state_d, state_q;
    logic [PW-1:0] wptr_d, wptr_q;
    logic [PW-1:0] rptr_d, rptr_q;
    logic [CW-1:0] count_d, count_q;
    logic [IW-1:0] idle_d, idle_q;
    logic          overflow_d, overflow_q;
    logic          halted_d, halted_q;
    logic [1:0]    cause_d, cause_q;
    logic          dump_valid_d, dump_valid_q;
    logic          dump_done_d, dump_done_q;

    logic          we_s;
    logic          re_s;
    logic          xfer_s;
    logic          end_hit_s;
    logic [CW-1:0] pend_s;
    logic [DW-1:0] inst_s;
    logic [DW-1:0] wdata_s;
    trace_rec_t    wr_rec_s;
    trace_rec_t    rd_rec_s;

    assign xfer_s    = dump_valid_q & bus.dump_ready;
    // Records still to be fetched from storage: the one in the output register is already out.
    assign pend_s    = dump_valid_q ? (count_q - CW'(1)) : count_q;
    assign end_hit_s = ({2'b00, bus.ret_pc[AW-1:2]} >= end_word);
    assign inst_s    = bus.ret_inst;
    assign wdata_s   = bus.ret_wdata;

`ifdef TRACE_CYCLE_STAMP_EN
    logic [15:0] cycle_d, cycle_q;

    // Free-running wrapping cycle counter.
    always_comb begin
        cycle_d = cycle_q + 16'd1;
    end

    // Cycle counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= 16'd0;
        end else begin
            cycle_q <= cycle_d;
        end
    end
`endif

    // Assemble the record to store from the retirement bus.
    always_comb begin
        wr_rec_s       = '0;
        wr_rec_s.pc    = bus.ret_pc;
        wr_rec_s.inst  = inst_s;
        wr_rec_s.rd    = bus.ret_rd;
        wr_rec_s.wdata = wdata_s;
`ifdef TRACE_CYCLE_STAMP_EN
        wr_rec_s.cycle = cycle_q;
`endif
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (we_s),
        .waddr (wptr_q),
        .wdata (wr_rec_s),
        .re    (re_s),
        .raddr (rptr_q),
        .rdata (rd_rec_s)
    );

    // FSM next state, pointers, counters, halt flags and dump handshake.
    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        idle_d       = idle_q;
        overflow_d   = overflow_q;
        halted_d     = halted_q;
        cause_d      = cause_q;
        dump_valid_d = dump_valid_q;
        dump_done_d  = dump_done_q;
        we_s         = 1'b0;
        re_s         = 1'b0;
        case (state_q)
            ST_CAPTURE: begin
                if (bus.ret_valid) begin
                    we_s   = 1'b1;
                    wptr_d = wptr_q + PW'(1);
                    idle_d = '0;
                    if (count_q == CW'(DEPTH)) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                    // The halting retirement itself is still recorded above.
                    if (end_hit_s) begin
                        halted_d = 1'b1;
                        cause_d  = CAUSE_END;
                        state_d  = ST_DRAIN;
                    end else begin
                        state_d  = ST_CAPTURE;
                    end
                end else begin
                    if (idle_q == IW'(STALL_LIMIT - 1)) begin
                        halted_d = 1'b1;
                        cause_d  = CAUSE_WDOG;
                        state_d  = ST_DRAIN;
                    end else begin
                        idle_d   = idle_q + IW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Oldest record sits at wptr once the buffer has wrapped.
                rptr_d = overflow_q ? wptr_q : '0;
                if (count_q == '0) begin
                    state_d     = ST_DONE;
                    dump_done_d = 1'b1;
                end else begin
                    state_d     = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (xfer_s) begin
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d     = ST_DONE;
                        dump_done_d = 1'b1;
                    end else begin
                        state_d     = ST_DUMP;
                    end
                end else begin
                    count_d = count_q;
                end
                // Prefetch the next record whenever the output slot is free or being emptied.
                if ((!dump_valid_q || xfer_s) && (pend_s != '0)) begin
                    re_s         = 1'b1;
                    rptr_d       = rptr_q + PW'(1);
                    dump_valid_d = 1'b1;
                end else if (xfer_s) begin
                    dump_valid_d = 1'b0;
                end else begin
                    dump_valid_d = dump_valid_q;
                end
            end
            ST_DONE: begin
                dump_valid_d = 1'b0;
                dump_done_d  = 1'b1;
            end
            default: begin
                state_d = ST_CAPTURE;
            end
        endcase
    end

    // State and output registers, all cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_CAPTURE;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            idle_q       <= '0;
            overflow_q   <= 1'b0;
            halted_q     <= 1'b0;
            cause_q      <= CAUSE_NONE;
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            idle_q       <= idle_d;
            overflow_q   <= overflow_d;
            halted_q     <= halted_d;
            cause_q      <= cause_d;
            dump_valid_q <= dump_valid_d;
            dump_done_q  <= dump_done_d;
        end
    end

    assign halted         = halted_q;
    assign halt_cause     = cause_q;
    assign overflow       = overflow_q;
    assign dump_done      = dump_done_q;
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_pc    = rd_rec_s.pc;
    assign bus.dump_inst  = rd_rec_s.inst;
    assign bus.dump_rd    = rd_rec_s.rd;
    assign bus.dump_wdata = rd_rec_s.wdata;
`ifdef TRACE_CYCLE_STAMP_EN
    assign bus.dump_cycle = rd_rec_s.cycle;
`endif

endmodule
